// File: rtl/bsram_ctrl_pkg.sv
// bsram_ctrl_pkg: shared types, widths and the byte-merge helper
// for the two-port Gowin_SP BSRAM bus controller.
package bsram_ctrl_pkg;

   localparam int DATA_W    = 32;
   localparam int MASK_W    = 4;
   localparam int NUM_PORTS = 2;
   localparam int PORT_W    = $clog2(NUM_PORTS);

   typedef enum logic [2:0] {
      IDLE,
      RD_ADDR,
      RD_OUT,
      RD_CAP,
      WR,
      DONE
   } state_t;

   function automatic logic [DATA_W-1:0] merge_bytes(
      input logic [DATA_W-1:0] old_w,
      input logic [DATA_W-1:0] new_w,
      input logic [MASK_W-1:0] mask
   );
      logic [DATA_W-1:0] m;
      m = old_w;
      for (int i = 0; i < MASK_W; i++) begin
         if (mask[i]) m[8*i +: 8] = new_w[8*i +: 8];
      end
      return m;
   endfunction

endpackage

// File: rtl/bsram_rr_arbiter.sv
// bsram_rr_arbiter: two-way round-robin picker. Priority moves only
// when the controller reports a finished access through upd.
module bsram_rr_arbiter
   import bsram_ctrl_pkg::*;
(
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NUM_PORTS-1:0] req,
   input  logic                 en,
   input  logic                 upd,
   input  logic [PORT_W-1:0]    upd_id,
   output logic                 gnt,
   output logic [PORT_W-1:0]    gnt_id
);

   logic [PORT_W-1:0] last;

   // last starts at port 1 so port 0 wins the first contested grant
   always_ff @(posedge clock or posedge reset) begin
      if (reset)    last <= PORT_W'(1);
      else if (upd) last <= upd_id;
   end

   always_comb begin
      gnt    = en && (|req);
      gnt_id = '0;
      unique case (req)
         2'b01:   gnt_id = PORT_W'(0);
         2'b10:   gnt_id = PORT_W'(1);
         2'b11:   gnt_id = ~last;
         default: gnt_id = '0;
      endcase
   end

endmodule

// File: rtl/bsram_bus_controller.sv
// bsram_bus_controller: shares one Gowin_SP BSRAM between two requesters,
// sequencing its registered-output read pipeline and RMW byte writes.
module bsram_bus_controller
   import bsram_ctrl_pkg::*;
#(
   parameter int ADDRESS_SIZE = 15,
   parameter int RAM_AW       = 11
) (
   input  logic                                   clock,
   input  logic                                   reset,
   input  logic [NUM_PORTS-1:0]                   req,
   input  logic [NUM_PORTS-1:0][ADDRESS_SIZE-1:0] addr,
   input  logic [NUM_PORTS-1:0]                   wr,
   input  logic [NUM_PORTS-1:0][MASK_W-1:0]       wmask,
   input  logic [NUM_PORTS-1:0][DATA_W-1:0]       wdata,
   output logic [NUM_PORTS-1:0]                   ready,
   output logic                                   err,
   output logic [DATA_W-1:0]                      rdata,
   output logic                                   ram_ce,
   output logic                                   ram_oce,
   output logic                                   ram_wre,
   output logic                                   ram_reset,
   output logic [RAM_AW-1:0]                      ram_ad,
   output logic [DATA_W-1:0]                      ram_din,
   input  logic [DATA_W-1:0]                      ram_dout
);

   state_t              state, n_state;
   logic [PORT_W-1:0]   port, n_port;
   logic                l_wr, n_wr;
   logic [MASK_W-1:0]   l_mask, n_mask;
   logic [DATA_W-1:0]   l_wdata, n_wdata;

   logic [NUM_PORTS-1:0] n_ready;
   logic                 n_err;
   logic [DATA_W-1:0]    n_rdata;
   logic                 n_ce, n_oce, n_wre;
   logic [RAM_AW-1:0]    n_ad;
   logic [DATA_W-1:0]    n_din;

   logic                    gnt;
   logic [PORT_W-1:0]       gnt_id;
   logic [ADDRESS_SIZE-1:0] g_addr;
   logic                    g_oor;
   logic                    unused_lo;

   assign g_addr    = addr[gnt_id];
   assign g_oor     = |g_addr[ADDRESS_SIZE-1:RAM_AW+2];
   assign unused_lo = ^g_addr[1:0];

   bsram_rr_arbiter u_arb (
      .clock  (clock),
      .reset  (reset),
      .req    (req),
      .en     (state == IDLE),
      .upd    (state == DONE),
      .upd_id (port),
      .gnt    (gnt),
      .gnt_id (gnt_id)
   );

   // Outputs are computed for the state being entered, then registered.
   always_comb begin
      n_state = state;
      n_port  = port;
      n_wr    = l_wr;
      n_mask  = l_mask;
      n_wdata = l_wdata;
      n_ready = '0;
      n_err   = 1'b0;
      n_rdata = rdata;
      n_ce    = 1'b0;
      n_oce   = 1'b0;
      n_wre   = 1'b0;
      n_ad    = ram_ad;
      n_din   = ram_din;
      unique case (state)
         IDLE: begin
            if (gnt) begin
               n_port  = gnt_id;
               n_wr    = wr[gnt_id];
               n_mask  = wmask[gnt_id];
               n_wdata = wdata[gnt_id];
               if (g_oor) begin
                  n_state         = DONE;
                  n_ready[gnt_id] = 1'b1;
                  n_err           = 1'b1;
               end else if (wr[gnt_id] && (&wmask[gnt_id])) begin
                  n_state = WR;
                  n_ce    = 1'b1;
                  n_wre   = 1'b1;
                  n_ad    = g_addr[RAM_AW+1:2];
                  n_din   = wdata[gnt_id];
               end else begin
                  n_state = RD_ADDR;
                  n_ce    = 1'b1;
                  n_ad    = g_addr[RAM_AW+1:2];
               end
            end
         end
         RD_ADDR: begin
            n_state = RD_OUT;
            n_oce   = 1'b1;
         end
         RD_OUT: begin
            n_state = RD_CAP;
         end
         RD_CAP: begin
            if (l_wr) begin
               n_state = WR;
               n_ce    = 1'b1;
               n_wre   = 1'b1;
               n_din   = merge_bytes(ram_dout, l_wdata, l_mask);
            end else begin
               n_state       = DONE;
               n_rdata       = ram_dout;
               n_ready[port] = 1'b1;
            end
         end
         WR: begin
            n_state       = DONE;
            n_ready[port] = 1'b1;
         end
         DONE: begin
            n_state = IDLE;
         end
         default: begin
            n_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         port      <= '0;
         l_wr      <= 1'b0;
         l_mask    <= '0;
         l_wdata   <= '0;
         ready     <= '0;
         err       <= 1'b0;
         rdata     <= '0;
         ram_ce    <= 1'b0;
         ram_oce   <= 1'b0;
         ram_wre   <= 1'b0;
         ram_ad    <= '0;
         ram_din   <= '0;
         ram_reset <= 1'b1;
      end else begin
         state     <= n_state;
         port      <= n_port;
         l_wr      <= n_wr;
         l_mask    <= n_mask;
         l_wdata   <= n_wdata;
         ready     <= n_ready;
         err       <= n_err;
         rdata     <= n_rdata;
         ram_ce    <= n_ce;
         ram_oce   <= n_oce;
         ram_wre   <= n_wre;
         ram_ad    <= n_ad;
         ram_din   <= n_din;
         ram_reset <= 1'b0;
      end
   end

endmodule
